// File: rtl/gin_tagged_fifo.sv
// Tagged GIN input buffer: a single FWFT FIFO holding {col_tag, row_tag, data} per entry,
// with occupancy, almost-full level, synchronous flush and sticky overflow error.
module gin_tagged_fifo #(
   parameter int unsigned DATA_WIDTH        = 64,
   parameter int unsigned ROW_TAG_WIDTH     = 4,
   parameter int unsigned COL_TAG_WIDTH     = 4,
   parameter int unsigned FIFO_DEPTH        = 16,
   parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush,
   input  logic                              wr_en,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic [ROW_TAG_WIDTH-1:0]          wr_row_tag,
   input  logic [COL_TAG_WIDTH-1:0]          wr_col_tag,
   output logic                              full,
   output logic                              almost_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
   output logic                              overflow_err,
   input  logic                              gin_ready,
   output logic                              gin_enable,
   output logic [DATA_WIDTH-1:0]             gin_data,
   output logic [ROW_TAG_WIDTH-1:0]          gin_row_tag,
   output logic [COL_TAG_WIDTH-1:0]          gin_col_tag
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned EW = COL_TAG_WIDTH + ROW_TAG_WIDTH + DATA_WIDTH;

   localparam logic [CW-1:0] FullLvl   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AlmostLvl = CW'(ALMOST_FULL_LEVEL);

   logic [EW-1:0] mem [FIFO_DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          not_empty;
   logic          push;
   logic          pop;

   // Status is decoded from the registered count, so a pop cannot make room for a
   // write in the same cycle.
   assign not_empty = (count_q != '0);
   assign full      = (count_q == FullLvl);
   assign push      = wr_en & ~full & ~flush;
   assign pop       = gin_ready & not_empty & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (wr_en && full) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is deliberately not reset or cleared; the output mux hides stale entries.
   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr_q] <= {wr_col_tag, wr_row_tag, wr_data};
   end

   always_comb begin
      {gin_col_tag, gin_row_tag, gin_data} = '0;
      if (not_empty) {gin_col_tag, gin_row_tag, gin_data} = mem[rd_ptr_q];
   end

   assign gin_enable   = pop;
   assign count        = count_q;
   assign almost_full  = (count_q >= AlmostLvl);
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_gin_tagged_fifo.sv
// Self-checking bench for gin_tagged_fifo: directed table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_gin_tagged_fifo;

   localparam int DEPTH = 16;
   localparam int AFL   = 12;

   logic        clk = 1'b0;
   logic        reset, flush, wr_en, gin_ready;
   logic [63:0] wr_data;
   logic [3:0]  wr_row_tag, wr_col_tag;
   logic        full, almost_full, overflow_err, gin_enable;
   logic [4:0]  count;
   logic [63:0] gin_data;
   logic [3:0]  gin_row_tag, gin_col_tag;

   always #5 clk = ~clk;

   gin_tagged_fifo #(
      .DATA_WIDTH(64), .ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(4),
      .FIFO_DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_row_tag(wr_row_tag), .wr_col_tag(wr_col_tag), .full(full),
      .almost_full(almost_full), .count(count), .overflow_err(overflow_err),
      .gin_ready(gin_ready), .gin_enable(gin_enable), .gin_data(gin_data),
      .gin_row_tag(gin_row_tag), .gin_col_tag(gin_col_tag)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [3:0]  r;
      logic [3:0]  c;
   } ent_t;

   ent_t mq[$];
   bit   m_ovf;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic rst, input logic fl, input logic we, input logic [63:0] d,
                        input logic [3:0] r, input logic [3:0] c, input logic rdy);
      reset = rst; flush = fl; wr_en = we; wr_data = d;
      wr_row_tag = r; wr_col_tag = c; gin_ready = rdy;
      #1;
   endtask

   task automatic model_check();
      ent_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      chk("count", 64'(count), 64'(mq.size()));
      chk("full", 64'(full), 64'(mq.size() == DEPTH));
      chk("almost_full", 64'(almost_full), 64'(mq.size() >= AFL));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      chk("gin_enable", 64'(gin_enable), 64'(gin_ready && mq.size() != 0 && !flush));
      chk("gin_data", gin_data, h.d);
      chk("gin_row_tag", 64'(gin_row_tag), 64'(h.r));
      chk("gin_col_tag", 64'(gin_col_tag), 64'(h.c));
   endtask

   task automatic tick();
      bit   was_full;
      ent_t tmp;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_ovf = 1'b0;
      end else if (flush) begin
         mq.delete();
      end else begin
         was_full = (mq.size() == DEPTH);
         if (gin_ready && mq.size() != 0) tmp = mq.pop_front();
         if (wr_en) begin
            if (was_full) m_ovf = 1'b1;
            else mq.push_back('{d: wr_data, r: wr_row_tag, c: wr_col_tag});
         end
      end
      #1;
   endtask

   task automatic cycle(input logic rst, input logic fl, input logic we, input logic [63:0] d,
                        input logic [3:0] r, input logic [3:0] c, input logic rdy);
      apply(rst, fl, we, d, r, c, rdy);
      model_check();
      tick();
   endtask

   typedef struct packed {
      logic        fl;
      logic        we;
      logic [63:0] d;
      logic [3:0]  r;
      logic [3:0]  c;
      logic        rdy;
      int          cnt;
      logic        en;
      logic [63:0] ed;
      logic [3:0]  er;
      logic [3:0]  ec;
   } vec_t;

   vec_t tbl[8];

   initial begin
      // Expected values are the outputs seen before the edge on which the inputs act.
      tbl[0] = '{1'b0, 1'b1, 64'hA5A5, 4'd3, 4'd7, 1'b0, 0, 1'b0, 64'h0,    4'd0, 4'd0};
      tbl[1] = '{1'b0, 1'b0, 64'h0,    4'd0, 4'd0, 1'b1, 1, 1'b1, 64'hA5A5, 4'd3, 4'd7};
      tbl[2] = '{1'b0, 1'b0, 64'h0,    4'd0, 4'd0, 1'b1, 0, 1'b0, 64'h0,    4'd0, 4'd0};
      tbl[3] = '{1'b0, 1'b1, 64'h11,   4'd1, 4'd2, 1'b1, 0, 1'b0, 64'h0,    4'd0, 4'd0};
      tbl[4] = '{1'b0, 1'b1, 64'h22,   4'd2, 4'd3, 1'b0, 1, 1'b0, 64'h11,   4'd1, 4'd2};
      tbl[5] = '{1'b0, 1'b1, 64'h33,   4'd4, 4'd5, 1'b1, 2, 1'b1, 64'h11,   4'd1, 4'd2};
      tbl[6] = '{1'b1, 1'b1, 64'h44,   4'd6, 4'd8, 1'b1, 2, 1'b0, 64'h22,   4'd2, 4'd3};
      tbl[7] = '{1'b0, 1'b0, 64'h0,    4'd0, 4'd0, 1'b1, 0, 1'b0, 64'h0,    4'd0, 4'd0};

      mq.delete();
      m_ovf = 1'b0;
      apply(1'b1, 1'b0, 1'b0, 64'h0, 4'd0, 4'd0, 1'b0);
      tick();
      tick();

      // Reset state
      apply(1'b0, 1'b0, 1'b0, 64'h0, 4'd0, 4'd0, 1'b1);
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_gin_enable", 64'(gin_enable), 64'd0);
      chk("reset_overflow", 64'(overflow_err), 64'd0);
      chk("reset_gin_data", gin_data, 64'd0);

      // Directed table
      for (int i = 0; i < 8; i++) begin
         apply(1'b0, tbl[i].fl, tbl[i].we, tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].rdy);
         chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d_enable", i), 64'(gin_enable), 64'(tbl[i].en));
         chk($sformatf("tbl%0d_data", i), gin_data, tbl[i].ed);
         chk($sformatf("tbl%0d_row", i), 64'(gin_row_tag), 64'(tbl[i].er));
         chk($sformatf("tbl%0d_col", i), 64'(gin_col_tag), 64'(tbl[i].ec));
         model_check();
         tick();
      end

      // Fill to full with GIN stalled
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 64'(i), 4'(i % 12), 4'(i % 14), 1'b0);
         chk("fill_almost_full", 64'(almost_full), 64'((i + 1) >= AFL));
         chk("fill_full", 64'(full), 64'((i + 1) == DEPTH));
         chk("fill_count", 64'(count), 64'(i + 1));
      end

      // Write while full is dropped
      cycle(1'b0, 1'b0, 1'b1, 64'hDEAD, 4'd9, 4'd9, 1'b0);
      chk("ovf_set", 64'(overflow_err), 64'd1);
      chk("ovf_count", 64'(count), 64'd16);

      // Drain in order with paired tags
      for (int i = 0; i < DEPTH; i++) begin
         apply(1'b0, 1'b0, 1'b0, 64'h0, 4'd0, 4'd0, 1'b1);
         chk("drain_enable", 64'(gin_enable), 64'd1);
         chk("drain_data", gin_data, 64'(i));
         chk("drain_row", 64'(gin_row_tag), 64'(i % 12));
         chk("drain_col", 64'(gin_col_tag), 64'(i % 14));
         model_check();
         tick();
      end
      apply(1'b0, 1'b0, 1'b0, 64'h0, 4'd0, 4'd0, 1'b1);
      chk("drained_count", 64'(count), 64'd0);
      chk("drained_enable", 64'(gin_enable), 64'd0);
      chk("drained_data", gin_data, 64'd0);

      // Steady push+pop at count 5 across pointer wrap
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 64'(200 + i), 4'(i), 4'(i), 1'b0);
      for (int k = 0; k < 20; k++) begin
         apply(1'b0, 1'b0, 1'b1, 64'(100 + k), 4'(k), 4'(k + 1), 1'b1);
         chk("wrap_count", 64'(count), 64'd5);
         chk("wrap_data", gin_data, (k < 5) ? 64'(200 + k) : 64'(100 + k - 5));
         model_check();
         tick();
      end

      // Flush dominates a write; overflow stays sticky
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 64'(300 + i), 4'd1, 4'd1, 1'b0);
      chk("pre_flush_count", 64'(count), 64'd9);
      cycle(1'b0, 1'b1, 1'b1, 64'hBEEF, 4'd5, 4'd5, 1'b1);
      apply(1'b0, 1'b0, 1'b0, 64'h0, 4'd0, 4'd0, 1'b1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_enable", 64'(gin_enable), 64'd0);
      chk("flush_data", gin_data, 64'd0);
      chk("flush_ovf_kept", 64'(overflow_err), 64'd1);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 64'(400 + i), 4'd2, 4'd2, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 64'h5555, 4'd3, 4'd3, 1'b0);
      apply(1'b0, 1'b0, 1'b0, 64'h0, 4'd0, 4'd0, 1'b1);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_af", 64'(almost_full), 64'd0);
      chk("rst_ovf", 64'(overflow_err), 64'd0);
      chk("rst_enable", 64'(gin_enable), 64'd0);
      chk("rst_data", gin_data, 64'd0);
      chk("rst_tags", 64'({gin_row_tag, gin_col_tag}), 64'd0);

      // Randomized traffic in fill / balanced / drain phases
      for (int k = 0; k < 3000; k++) begin
         int   phase;
         logic rst, fl, we, rdy;
         phase = (k / 300) % 3;
         rst   = ($urandom_range(0, 249) == 0);
         fl    = ($urandom_range(0, 39) == 0);
         case (phase)
            0:       begin we = ($urandom_range(0, 9) < 9); rdy = ($urandom_range(0, 9) < 2); end
            1:       begin we = ($urandom_range(0, 1) == 1); rdy = ($urandom_range(0, 1) == 1); end
            default: begin we = ($urandom_range(0, 9) < 2); rdy = ($urandom_range(0, 9) < 9); end
         endcase
         if (fl) we = 1'b0;
         cycle(rst, fl, we, {$urandom, $urandom}, 4'($urandom), 4'($urandom), rdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
